// File: rtl/cfixmul_pipe.sv
// cfixmul_pipe: 3-stage pipelined complex fixed-point multiplier (a * b or a * conj(b))
// with round-half-up, output saturation, sticky saturation flag and valid/ready flow control.
module cfixmul_pipe #(
    parameter int IN_BITS  = 19,
    parameter int IN_FRAC  = 17,
    parameter int OUT_BITS = 19,
    parameter int OUT_FRAC = 17
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic                       i_in_conj,
    input  logic signed [IN_BITS-1:0]  i_a_re,
    input  logic signed [IN_BITS-1:0]  i_a_im,
    input  logic signed [IN_BITS-1:0]  i_b_re,
    input  logic signed [IN_BITS-1:0]  i_b_im,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic signed [OUT_BITS-1:0] o_p_re,
    output logic signed [OUT_BITS-1:0] o_p_im,
    output logic                       o_out_sat,
    input  logic                       i_sat_clr,
    output logic                       o_sat_sticky
);
    localparam int PW = 2 * IN_BITS;
    localparam int SW = PW + 1;
    localparam int SH = 2 * IN_FRAC - OUT_FRAC;
    localparam logic signed [SW-1:0] RND  = SW'(1) <<< (SH - 1);
    localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (OUT_BITS - 1)) - SW'(1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    // Returns {clamped, value}
    function automatic logic [OUT_BITS:0] sat_fn(input logic signed [SW-1:0] v);
        return (v > MAXV) ? {1'b1, MAXV[OUT_BITS-1:0]} :
               (v < MINV) ? {1'b1, MINV[OUT_BITS-1:0]} : {1'b0, v[OUT_BITS-1:0]};
    endfunction

    logic                      r_v1, r_v2, r_v3;
    logic                      r_conj1, r_conj2;
    logic signed [IN_BITS-1:0] r_ar, r_ai, r_br, r_bi;
    logic signed [PW-1:0]      r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [OUT_BITS-1:0] r_pre, r_pim;
    logic                      r_sat, r_sticky;

    logic                      w_ld1, w_ld2, w_ld3;
    logic signed [SW-1:0]      w_rr, w_ii, w_ri, w_ir;
    logic signed [SW-1:0]      w_sum_re, w_sum_im, w_rnd_re, w_rnd_im;
    logic [OUT_BITS:0]         w_c_re, w_c_im;

    // Each stage advances when empty or when the stage after it advances.
    assign w_ld3 = !r_v3 || i_out_ready;
    assign w_ld2 = !r_v2 || w_ld3;
    assign w_ld1 = !r_v1 || w_ld2;
    assign o_in_ready = w_ld1;

    assign w_rr = r_p_rr;
    assign w_ii = r_p_ii;
    assign w_ri = r_p_ri;
    assign w_ir = r_p_ir;
    assign w_sum_re = r_conj2 ? w_rr + w_ii : w_rr - w_ii;
    assign w_sum_im = r_conj2 ? w_ir - w_ri : w_ri + w_ir;
    assign w_rnd_re = (w_sum_re + RND) >>> SH;
    assign w_rnd_im = (w_sum_im + RND) >>> SH;
    assign w_c_re = sat_fn(w_rnd_re);
    assign w_c_im = sat_fn(w_rnd_im);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v1    <= 1'b0;
            r_conj1 <= 1'b0;
            r_ar    <= '0;
            r_ai    <= '0;
            r_br    <= '0;
            r_bi    <= '0;
        end else if (w_ld1) begin
            r_v1    <= i_in_valid;
            r_conj1 <= i_in_conj;
            r_ar    <= i_a_re;
            r_ai    <= i_a_im;
            r_br    <= i_b_re;
            r_bi    <= i_b_im;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v2    <= 1'b0;
            r_conj2 <= 1'b0;
            r_p_rr  <= '0;
            r_p_ii  <= '0;
            r_p_ri  <= '0;
            r_p_ir  <= '0;
        end else if (w_ld2) begin
            r_v2    <= r_v1;
            r_conj2 <= r_conj1;
            r_p_rr  <= r_ar * r_br;
            r_p_ii  <= r_ai * r_bi;
            r_p_ri  <= r_ar * r_bi;
            r_p_ir  <= r_ai * r_br;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v3  <= 1'b0;
            r_pre <= '0;
            r_pim <= '0;
            r_sat <= 1'b0;
        end else if (w_ld3) begin
            r_v3  <= r_v2;
            r_pre <= w_c_re[OUT_BITS-1:0];
            r_pim <= w_c_im[OUT_BITS-1:0];
            r_sat <= w_c_re[OUT_BITS] | w_c_im[OUT_BITS];
        end
    end

    // A saturated beat leaving the block beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_sticky <= 1'b0;
        else if (r_v3 && i_out_ready && r_sat)
            r_sticky <= 1'b1;
        else if (i_sat_clr)
            r_sticky <= 1'b0;
    end

    assign o_out_valid  = r_v3;
    assign o_p_re       = r_pre;
    assign o_p_im       = r_pim;
    assign o_out_sat    = r_sat;
    assign o_sat_sticky = r_sticky;
endmodule

// File: tb/tb_cfixmul_pipe.sv
// tb_cfixmul_pipe: directed and randomized checks of cfixmul_pipe against an arithmetic
// reference model (Q1.17 in and out).
module tb_cfixmul_pipe;
    localparam int IB = 19;
    localparam int IF = 17;
    localparam int OB = 19;
    localparam int OF = 17;
    localparam int SH = 2 * IF - OF;

    typedef struct {
        longint re;
        longint im;
        logic   sat;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_conj = 1'b0;
    logic out_ready = 1'b1;
    logic sat_clr = 1'b0;
    logic signed [IB-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic in_ready, out_valid, out_sat, sat_sticky;
    logic signed [OB-1:0] p_re, p_im;

    res_t exp_q[$];
    res_t e;
    int n_vec = 0;
    int n_err = 0;
    logic m_sticky = 1'b0;
    logic hold_v = 1'b0;
    logic hold_sat;
    logic signed [OB-1:0] hold_re, hold_im;

    always #5 clk = ~clk;

    cfixmul_pipe #(.IN_BITS(IB), .IN_FRAC(IF), .OUT_BITS(OB), .OUT_FRAC(OF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_conj(in_conj), .i_a_re(a_re), .i_a_im(a_im), .i_b_re(b_re), .i_b_im(b_im),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_p_re(p_re), .o_p_im(p_im),
        .o_out_sat(out_sat), .i_sat_clr(sat_clr), .o_sat_sticky(sat_sticky)
    );

    function automatic longint clampv(input longint v);
        longint hi = (longint'(1) <<< (OB - 1)) - 1;
        return v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
    endfunction

    function automatic res_t model(input longint ar, input longint ai, input longint br,
                                   input longint bi, input logic conj);
        res_t r;
        longint sr = conj ? ar * br + ai * bi : ar * br - ai * bi;
        longint si = conj ? ai * br - ar * bi : ar * bi + ai * br;
        longint qr = (sr + (longint'(1) <<< (SH - 1))) >>> SH;
        longint qi = (si + (longint'(1) <<< (SH - 1))) >>> SH;
        r.re  = clampv(qr);
        r.im  = clampv(qi);
        r.sat = (r.re != qr) || (r.im != qi);
        return r;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: sampled on the falling edge, predicting what the next rising edge transfers.
    always @(negedge clk) begin
        if (hold_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_re", p_re, hold_re);
            chk("hold_im", p_im, hold_im);
            chk("hold_sat", out_sat, hold_sat);
        end
        chk("sticky", sat_sticky, m_sticky);
        if (out_valid && exp_q.size() == 0)
            chk("stale_out", out_valid, 0);
        if (!rst_n) begin
            exp_q.delete();
            m_sticky = 1'b0;
            hold_v = 1'b0;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("p_re", p_re, e.re);
                chk("p_im", p_im, e.im);
                chk("out_sat", out_sat, e.sat);
                m_sticky = e.sat ? 1'b1 : (sat_clr ? 1'b0 : m_sticky);
            end else if (sat_clr) begin
                m_sticky = 1'b0;
            end
            hold_v = out_valid && !out_ready;
            hold_re = p_re;
            hold_im = p_im;
            hold_sat = out_sat;
            if (in_valid && in_ready)
                exp_q.push_back(model(a_re, a_im, b_re, b_im, in_conj));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic signed [IB-1:0] ar, input logic signed [IB-1:0] ai,
                          input logic signed [IB-1:0] br, input logic signed [IB-1:0] bi,
                          input logic conj);
        a_re = ar; a_im = ai; b_re = br; b_im = bi; in_conj = conj;
    endtask

    task automatic send(input logic signed [IB-1:0] ar, input logic signed [IB-1:0] ai,
                        input logic signed [IB-1:0] br, input logic signed [IB-1:0] bi,
                        input logic conj);
        set_op(ar, ai, br, bi, conj);
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("wait_out", out_valid, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic one(input string tag, input logic signed [IB-1:0] ar, input logic signed [IB-1:0] ai,
                       input logic signed [IB-1:0] br, input logic signed [IB-1:0] bi, input logic conj,
                       input longint xre, input longint xim, input logic xsat);
        drain();
        send(ar, ai, br, bi, conj);
        wait_out();
        chk({tag, "_re"}, p_re, xre);
        chk({tag, "_im"}, p_im, xim);
        chk({tag, "_sat"}, out_sat, xsat);
    endtask

    function automatic logic signed [IB-1:0] rop();
        case ($urandom_range(0, 7))
            0: return -19'sd262144;
            1: return 19'sd262143;
            2: return '0;
            3: return 19'sd131072;
            default: return IB'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        logic blocked, seen;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_p_re", p_re, 0);
        chk("rst_p_im", p_im, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_sticky", sat_sticky, 0);
        chk("rst_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        drain();
        set_op(19'sd131072, 0, 19'sd65536, 19'sd65536, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_c1", out_valid, 0);
        @(negedge clk);
        chk("lat_c2", out_valid, 0);
        @(negedge clk);
        chk("lat_c3", out_valid, 1);
        chk("lat_re", p_re, 65536);
        chk("lat_im", p_im, 65536);

        one("sat", -19'sd262144, 0, -19'sd262144, 0, 1'b0, 262143, 0, 1'b1);
        repeat (3) @(negedge clk);
        chk("sticky_held", sat_sticky, 1);
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr", sat_sticky, 0);

        one("conj1", 0, 19'sd131072, 0, 19'sd131072, 1'b1, 131072, 0, 1'b0);
        one("conj0", 0, 19'sd131072, 0, 19'sd131072, 1'b0, -131072, 0, 1'b0);
        one("rnd_pos", 19'sd1, 0, 19'sd65536, 0, 1'b0, 1, 0, 1'b0);
        one("rnd_neg", -19'sd1, 0, 19'sd65536, 0, 1'b0, 0, 0, 1'b0);

        drain();
        tick();
        k = 0;
        blocked = 1'b0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 4 && c <= 9);
            in_valid = k < 8;
            set_op(rop(), rop(), rop(), rop(), 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (in_valid && in_ready) k++;
            if (!in_ready) blocked = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stall_block", blocked, 1);
        chk("stream_cnt", k, 8);
        drain();

        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 3) != 0;
            sat_clr = $urandom_range(0, 19) == 0;
            set_op(rop(), rop(), rop(), rop(), 1'($urandom_range(0, 1)));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        sat_clr = 1'b0;
        drain();

        for (int b = 0; b < 3; b++) begin
            set_op(-19'sd262144, rop(), -19'sd262144, rop(), 1'b0);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sticky", sat_sticky, 0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("no_stale", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
